// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: divides i_clk by a run-time half-period, emits a
// CPOL-correct burst of 2*N SCLK edges and CPHA-placed sample/shift strobes.
//
//   state | meaning
//   IDLE  | SCLK follows i_cpol, counters cleared, waiting for i_start
//   RUN   | SCLK toggling, one edge per half period, strobes issued
//   TRAIL | SCLK parked at latched cpol for one half period before o_done
module spi_sclk_gen #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cpol,
   input  logic             i_cpha,
   input  logic [DIV_W-1:0] i_div,
   input  logic [CNT_W-1:0] i_nbits,
   input  logic             i_start,
   output logic             o_sclk,
   output logic             o_busy,
   output logic             o_sample,
   output logic             o_shift,
   output logic             o_done,
   output logic [CNT_W-1:0] o_bit_idx
);

   typedef enum logic [1:0] {IDLE, RUN, TRAIL} state_t;

   state_t           state, state_nxt;
   logic             cpol_q, cpha_q;
   logic [DIV_W-1:0] div_q;
   logic [CNT_W-1:0] nbits_q;
   logic [DIV_W-1:0] hcnt, hcnt_nxt;
   logic [CNT_W:0]   ecnt, ecnt_nxt;
   logic             sclk_nxt, sample_nxt, shift_nxt, done_nxt, load;
   logic [CNT_W-1:0] bit_idx_nxt;

   logic             half_done;
   logic [CNT_W:0]   edge_num;
   logic             last_edge;
   logic [CNT_W-1:0] last_idx;

   assign half_done = (hcnt == div_q);
   assign edge_num  = ecnt + (CNT_W+1)'(1);
   assign last_edge = (edge_num == {nbits_q, 1'b0});
   assign last_idx  = nbits_q - CNT_W'(1);
   assign o_busy    = (state != IDLE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      hcnt_nxt    = hcnt;
      ecnt_nxt    = ecnt;
      sclk_nxt    = o_sclk;
      sample_nxt  = 1'b0;
      shift_nxt   = 1'b0;
      done_nxt    = 1'b0;
      load        = 1'b0;
      bit_idx_nxt = o_bit_idx;
      // Index advances the cycle after a sample, so it names the bit being sampled.
      if (o_sample && (o_bit_idx != last_idx)) bit_idx_nxt = o_bit_idx + CNT_W'(1);
      case (state)
         IDLE: begin
            sclk_nxt    = i_cpol;
            hcnt_nxt    = '0;
            ecnt_nxt    = '0;
            bit_idx_nxt = '0;
            if (i_start && (i_nbits != '0)) begin
               state_nxt = RUN;
               load      = 1'b1;
            end
         end
         RUN: begin
            if (half_done) begin
               hcnt_nxt = '0;
               ecnt_nxt = edge_num;
               sclk_nxt = cpol_q ^ edge_num[0];
               if (cpha_q) begin
                  shift_nxt  = edge_num[0];
                  sample_nxt = ~edge_num[0];
               end else begin
                  sample_nxt = edge_num[0];
                  shift_nxt  = ~edge_num[0] && !last_edge;
               end
               if (last_edge) state_nxt = TRAIL;
            end else begin
               hcnt_nxt = hcnt + DIV_W'(1);
            end
         end
         TRAIL: begin
            sclk_nxt = cpol_q;
            if (half_done) begin
               hcnt_nxt  = '0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               hcnt_nxt = hcnt + DIV_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         div_q     <= '0;
         nbits_q   <= '0;
         hcnt      <= '0;
         ecnt      <= '0;
         o_sclk    <= 1'b0;
         o_sample  <= 1'b0;
         o_shift   <= 1'b0;
         o_done    <= 1'b0;
         o_bit_idx <= '0;
      end else begin
         if (load) begin
            cpol_q  <= i_cpol;
            cpha_q  <= i_cpha;
            div_q   <= i_div;
            nbits_q <= i_nbits;
         end
         hcnt      <= hcnt_nxt;
         ecnt      <= ecnt_nxt;
         o_sclk    <= sclk_nxt;
         o_sample  <= sample_nxt;
         o_shift   <= shift_nxt;
         o_done    <= done_nxt;
         o_bit_idx <= bit_idx_nxt;
      end
   end

endmodule
